// File: rtl/sqrl_uart_packet_rx.sv
`default_nettype none
// ============================================================================
// Module   : sqrl_uart_packet_rx
// Purpose  : Packet framer behind a UART byte receiver. Hunts for frames of
//            the form SYNC, LEN, PAYLOAD[LEN], CSUM. The payload is buffered
//            and released only after the checksum verifies. It is then
//            streamed out with a valid/ready handshake. Faults are reported
//            as registered one-cycle pulses.
// Ports    : clk, rst_n         - clock, synchronous active-low reset
//            rx_new_byte/rx_byte - one-cycle byte strobe from the UART
//            m_valid/m_ready/m_data/m_last/m_len - payload stream out
//            err_checksum/err_length/err_timeout/err_overrun - fault pulses
// Revision : 1.0 - initial release
// ============================================================================
module sqrl_uart_packet_rx #(
   parameter int         MAX_PAYLOAD    = 32,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_new_byte,
   input  logic [7:0] rx_byte,
   output logic       m_valid,
   input  logic       m_ready,
   output logic [7:0] m_data,
   output logic       m_last,
   output logic [7:0] m_len,
   output logic       err_checksum,
   output logic       err_length,
   output logic       err_timeout,
   output logic       err_overrun
);

   localparam int c_PTR_W = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
   localparam int c_CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [7:0]         c_MAX_LEN = 8'(MAX_PAYLOAD);
   localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_HUNT    = 3'd0,
      ST_LEN     = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_CSUM    = 3'd3,
      ST_DRAIN   = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [7:0]           r_len;
   logic [7:0]           r_sum;
   logic [c_PTR_W-1:0]   r_wr_ptr;
   logic [c_PTR_W-1:0]   r_rd_ptr;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [7:0]           r_m_len;
   logic [7:0]           r_buf [MAX_PAYLOAD];
   logic                 r_err_checksum;
   logic                 r_err_length;
   logic                 r_err_timeout;
   logic                 r_err_overrun;

   logic                 w_err_checksum;
   logic                 w_err_length;
   logic                 w_err_timeout;
   logic                 w_err_overrun;
   logic                 w_in_frame;
   logic                 w_expire;
   logic                 w_len_bad;
   logic [7:0]           w_len_m1;
   logic                 w_wr_last;
   logic                 w_rd_last;
   logic [7:0]           w_csum_total;
   logic                 w_csum_ok;
   logic                 w_xfer;

   assign w_in_frame   = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) ||
                         (r_state == ST_CSUM);
   // A byte on the expiry cycle wins over the timeout.
   assign w_expire     = w_in_frame && !rx_new_byte && (r_cnt == c_TO_LAST);
   assign w_len_bad    = (rx_byte == 8'd0) || (rx_byte > c_MAX_LEN);
   assign w_len_m1     = r_len - 8'd1;
   assign w_wr_last    = (8'(r_wr_ptr) == w_len_m1);
   assign w_rd_last    = (8'(r_rd_ptr) == w_len_m1);
   assign w_csum_total = r_sum + rx_byte;
   assign w_csum_ok    = (w_csum_total == 8'd0);
   assign w_xfer       = m_valid && m_ready;

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_HUNT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state and error pulse requests
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt    = r_state;
      w_err_checksum = 1'b0;
      w_err_length   = 1'b0;
      w_err_timeout  = 1'b0;
      w_err_overrun  = 1'b0;
      case (r_state)
         ST_HUNT: begin
            if (rx_new_byte && (rx_byte == SYNC_BYTE)) begin
               w_state_nxt = ST_LEN;
            end
         end
         ST_LEN: begin
            if (rx_new_byte) begin
               if (w_len_bad) begin
                  w_err_length = 1'b1;
                  w_state_nxt  = ST_HUNT;
               end else begin
                  w_state_nxt  = ST_PAYLOAD;
               end
            end else if (w_expire) begin
               w_err_timeout = 1'b1;
               w_state_nxt   = ST_HUNT;
            end
         end
         ST_PAYLOAD: begin
            if (rx_new_byte) begin
               if (w_wr_last) begin
                  w_state_nxt = ST_CSUM;
               end
            end else if (w_expire) begin
               w_err_timeout = 1'b1;
               w_state_nxt   = ST_HUNT;
            end
         end
         ST_CSUM: begin
            if (rx_new_byte) begin
               if (w_csum_ok) begin
                  w_state_nxt    = ST_DRAIN;
               end else begin
                  w_err_checksum = 1'b1;
                  w_state_nxt    = ST_HUNT;
               end
            end else if (w_expire) begin
               w_err_timeout = 1'b1;
               w_state_nxt   = ST_HUNT;
            end
         end
         ST_DRAIN: begin
            // Bytes arriving while draining are dropped, frame not restarted.
            w_err_overrun = rx_new_byte;
            if (w_xfer && w_rd_last) begin
               w_state_nxt = ST_HUNT;
            end
         end
         default: begin
            w_state_nxt = ST_HUNT;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Registered error pulses
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_err_checksum <= 1'b0;
         r_err_length   <= 1'b0;
         r_err_timeout  <= 1'b0;
         r_err_overrun  <= 1'b0;
      end else begin
         r_err_checksum <= w_err_checksum;
         r_err_length   <= w_err_length;
         r_err_timeout  <= w_err_timeout;
         r_err_overrun  <= w_err_overrun;
      end
   end

   // ---------------------------------------------------------------------
   // Datapath: length, running sum, pointers, inter-byte timer
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_len    <= 8'd0;
         r_sum    <= 8'd0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
         r_m_len  <= 8'd0;
      end else begin
         // Timer is held at zero outside a frame; entry to LEN is always
         // caused by a byte, so that clear covers the entry case too.
         if (rx_new_byte || !w_in_frame) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end

         case (r_state)
            ST_LEN: begin
               if (rx_new_byte && !w_len_bad) begin
                  r_len    <= rx_byte;
                  r_sum    <= rx_byte;
                  r_wr_ptr <= '0;
               end
            end
            ST_PAYLOAD: begin
               if (rx_new_byte) begin
                  r_wr_ptr <= r_wr_ptr + 1'b1;
                  r_sum    <= r_sum + rx_byte;
               end
            end
            ST_CSUM: begin
               if (rx_new_byte && w_csum_ok) begin
                  r_m_len  <= r_len;
                  r_rd_ptr <= '0;
               end
            end
            ST_DRAIN: begin
               if (w_xfer) begin
                  r_rd_ptr <= r_rd_ptr + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Payload storage needs no reset: it is only read after being written.
   always_ff @(posedge clk) begin
      if ((r_state == ST_PAYLOAD) && rx_new_byte) begin
         r_buf[r_wr_ptr] <= rx_byte;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign m_valid      = (r_state == ST_DRAIN);
   assign m_data       = m_valid ? r_buf[r_rd_ptr] : 8'd0;
   assign m_last       = m_valid && w_rd_last;
   assign m_len        = r_m_len;
   assign err_checksum = r_err_checksum;
   assign err_length   = r_err_length;
   assign err_timeout  = r_err_timeout;
   assign err_overrun  = r_err_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sqrl_uart_packet_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_sqrl_uart_packet_rx
// Purpose  : Self-checking bench for sqrl_uart_packet_rx. Expected payload
//            bytes are queued when frames are sent and popped on transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sqrl_uart_packet_rx;

   localparam int         c_MAX = 32;
   localparam logic [7:0] c_SYNC = 8'hA5;
   localparam int         c_TO  = 20;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_new_byte = 1'b0;
   logic [7:0] rx_byte = 8'd0;
   logic       m_valid;
   logic       m_ready = 1'b1;
   logic [7:0] m_data;
   logic       m_last;
   logic [7:0] m_len;
   logic       err_checksum;
   logic       err_length;
   logic       err_timeout;
   logic       err_overrun;

   int checks = 0;
   int errors = 0;

   // Expected transfer: {last, len, data}
   logic [16:0] exp_q [$];

   int n_cs = 0, n_len = 0, n_to = 0, n_ov = 0, n_valid = 0;
   int s_cs, s_len, s_to, s_ov, s_valid;

   logic       stall_prev = 1'b0;
   logic [7:0] hold_data;
   logic       hold_last;

   sqrl_uart_packet_rx #(
      .MAX_PAYLOAD    (c_MAX),
      .SYNC_BYTE      (c_SYNC),
      .TIMEOUT_CYCLES (c_TO)
   ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_new_byte  (rx_new_byte),
      .rx_byte      (rx_byte),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_last       (m_last),
      .m_len        (m_len),
      .err_checksum (err_checksum),
      .err_length   (err_length),
      .err_timeout  (err_timeout),
      .err_overrun  (err_overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Monitor: scoreboard pops, stall stability, error pulse counting.
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (err_checksum) n_cs++;
         if (err_length)   n_len++;
         if (err_timeout)  n_to++;
         if (err_overrun)  n_ov++;
         if (m_valid)      n_valid++;
         if (stall_prev) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, hold_data);
            chk("hold_last", m_last, hold_last);
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_xfer", 1, 0);
            end else begin
               logic [16:0] e;
               e = exp_q.pop_front();
               chk("m_data", m_data, e[7:0]);
               chk("m_len", m_len, e[15:8]);
               chk("m_last", m_last, e[16]);
            end
         end
         stall_prev = m_valid && !m_ready;
         hold_data  = m_data;
         hold_last  = m_last;
      end
   end

   // All driving happens 1 time unit after a rising edge.
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_new_byte = 1'b1;
      rx_byte     = b;
      @(posedge clk);
      #1;
      rx_new_byte = 1'b0;
      rx_byte     = 8'd0;
   endtask

   task automatic send_frame(input logic [7:0] pl[$], input bit good, input bit expect_out);
      logic [7:0] sum;
      logic [7:0] len;
      len = 8'(pl.size());
      sum = len;
      foreach (pl[i]) sum = sum + pl[i];
      if (expect_out) begin
         foreach (pl[i]) exp_q.push_back({(i == pl.size() - 1), len, pl[i]});
      end
      send(c_SYNC);
      send(len);
      foreach (pl[i]) send(pl[i]);
      send(good ? (8'd0 - sum) : (8'd1 - sum));
   endtask

   task automatic wait_drain(input string tag);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 200) begin
         idle(1);
         k++;
      end
      chk(tag, exp_q.size(), 0);
      idle(2);
   endtask

   task automatic snap();
      s_cs = n_cs; s_len = n_len; s_to = n_to; s_ov = n_ov; s_valid = n_valid;
   endtask

   task automatic chk_errs(input string tag, input int cs, input int ln, input int to, input int ov);
      chk({tag, "_err_checksum"}, n_cs - s_cs, cs);
      chk({tag, "_err_length"}, n_len - s_len, ln);
      chk({tag, "_err_timeout"}, n_to - s_to, to);
      chk({tag, "_err_overrun"}, n_ov - s_ov, ov);
   endtask

   initial begin
      logic [7:0] pl[$];
      logic       pat[4];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};

      // Reset state
      idle(3);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_len", m_len, 0);
      chk("rst_errs", {err_checksum, err_length, err_timeout, err_overrun}, 0);
      rst_n = 1'b1;
      idle(2);

      // Good 3-byte frame
      snap();
      pl = '{8'h11, 8'h22, 8'h33};
      send_frame(pl, 1, 1);
      chk("latency_valid", m_valid, 1);
      chk("latency_data", m_data, 8'h11);
      wait_drain("drain_good3");
      chk("good3_valid_cycles", n_valid - s_valid, 3);
      chk("good3_m_len", m_len, 3);
      chk("idle_m_valid", m_valid, 0);
      chk("idle_m_data", m_data, 0);
      chk_errs("good3", 0, 0, 0, 0);

      // Bad checksum, then a good frame
      snap();
      send_frame(pl, 0, 0);
      idle(4);
      chk("badcs_valid_cycles", n_valid - s_valid, 0);
      chk_errs("badcs", 1, 0, 0, 0);
      pl = '{8'h5A, 8'hA5};
      send_frame(pl, 1, 1);
      wait_drain("drain_after_badcs");

      // Length errors: 0 and MAX+1
      snap();
      send(c_SYNC); send(8'h00);
      idle(2);
      send(c_SYNC); send(8'h21);
      idle(2);
      chk_errs("badlen", 0, 2, 0, 0);
      chk("badlen_valid_cycles", n_valid - s_valid, 0);

      // Inter-byte timeout, pulse timing exact
      snap();
      send(c_SYNC); send(8'h02); send(8'h10);
      idle(c_TO - 1);
      chk("to_early", err_timeout, 0);
      idle(1);
      chk("to_pulse", err_timeout, 1);
      idle(1);
      chk("to_pulse_end", err_timeout, 0);
      idle(c_TO + 5);
      chk_errs("timeout", 0, 0, 1, 0);

      // Byte on the expiry cycle suppresses the timeout
      snap();
      exp_q.push_back({1'b0, 8'd2, 8'h10});
      exp_q.push_back({1'b1, 8'd2, 8'h20});
      send(c_SYNC); send(8'h02); send(8'h10);
      idle(c_TO - 1);
      send(8'h20);
      send(8'hCE);
      wait_drain("drain_to_boundary");
      chk_errs("to_boundary", 0, 0, 0, 0);

      // Stalled drain with overruns (one on the final transfer cycle)
      snap();
      pl = '{8'h01, 8'h02, 8'h03, 8'h04};
      send_frame(pl, 1, 1);
      for (int i = 0; i < 8; i++) begin
         m_ready     = pat[i % 4];
         rx_new_byte = (i == 2) || (i == 7);
         rx_byte     = (i == 2) ? c_SYNC : 8'h33;
         @(posedge clk);
         #1;
      end
      m_ready     = 1'b1;
      rx_new_byte = 1'b0;
      wait_drain("drain_stall");
      chk("stall_m_len", m_len, 4);
      chk_errs("stall", 0, 0, 0, 2);

      // Garbage then a 1-byte frame whose payload equals the sync value
      snap();
      send(8'h00); send(8'hFF); send(8'h13);
      exp_q.push_back({1'b1, 8'd1, 8'hA5});
      send(c_SYNC); send(8'h01); send(8'hA5); send(8'h5A);
      wait_drain("drain_sync_payload");
      chk("sync_m_len", m_len, 1);
      chk_errs("sync", 0, 0, 0, 0);

      // Reset in the middle of a drain
      snap();
      m_ready = 1'b0;
      pl = '{8'h77, 8'h88};
      send_frame(pl, 1, 0);
      chk("pre_rst_valid", m_valid, 1);
      rst_n = 1'b0;
      idle(1);
      chk("rst_drain_valid", m_valid, 0);
      chk("rst_drain_m_len", m_len, 0);
      rst_n   = 1'b1;
      m_ready = 1'b1;
      snap();
      idle(4);
      chk("post_rst_valid_cycles", n_valid - s_valid, 0);
      chk_errs("rst_drain", 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
